// File: rtl/jtag_user_seq_if.sv
// Purpose: command/response and USER1/USER2 signal bundle for jtag_user_seq.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; rsp_valid is a one-cycle pulse with no ready.
// Ports: cmd_* command request, rsp_* completion, sel/capture/shift/update/tdi/tdo 1 and 2.
interface jtag_user_seq_if #(
  parameter int IR_LEN = 8,
  parameter int DR_MAX = 32,
  parameter int LW     = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_LEN-1:0] cmd_func;
  logic              cmd_skip_ir;
  logic [LW-1:0]     cmd_len;
  logic [DR_MAX-1:0] cmd_data;

  logic              rsp_valid;
  logic [DR_MAX-1:0] rsp_data;
  logic [IR_LEN-1:0] rsp_ir;

  logic sel1, capture1, shift1, update1, tdi1, tdo1;
  logic sel2, capture2, shift2, update2, tdi2, tdo2;

  // Command issuer / USER-register side.
  modport master (
    output cmd_valid, cmd_func, cmd_skip_ir, cmd_len, cmd_data, tdo1, tdo2,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir,
    input  sel1, capture1, shift1, update1, tdi1,
    input  sel2, capture2, shift2, update2, tdi2
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_func, cmd_skip_ir, cmd_len, cmd_data, tdo1, tdo2,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir,
    output sel1, capture1, shift1, update1, tdi1,
    output sel2, capture2, shift2, update2, tdi2
  );
endinterface

// File: rtl/jtag_user_seq.sv
// Purpose: sequences USER1 (function code) and USER2 (data) shifts from a parallel command.
// Latency: full IR_LEN+6+L cycles, skip-IR L+3, IR-only IR_LEN+3, skip-IR with LEN=0 1 cycle.
// Backpressure: cmd_ready only in IDLE/DONE; a command offered in DONE is taken with no bubble.
// Ports: clk_i (also acts as TCK), rst_ni async active-low, bus = jtag_user_seq_if.slave.
module jtag_user_seq #(
  parameter int IR_LEN = 8,
  parameter int DR_MAX = 32,
  parameter int LW     = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  jtag_user_seq_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, IR_CAP, IR_SHIFT, IR_UPD, GAP, DR_CAP, DR_SHIFT, DR_UPD, DONE
  } state_e;

  localparam int CMAX = (IR_LEN > DR_MAX) ? IR_LEN : DR_MAX;
  localparam int CW   = $clog2(CMAX);
  localparam logic [31:0] IR_LAST  = IR_LEN - 1;
  localparam logic [31:0] DR_MAX_U = DR_MAX;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IR_LEN-1:0] func_q, func_d;
  logic              skip_q, skip_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DR_MAX-1:0] data_q, data_d;
  // Capture shadows; they only reach rsp_* on entry to DONE so the
  // previous response stays stable while the next command is shifting.
  logic [IR_LEN-1:0] ir_sh_q, ir_sh_d;
  logic [DR_MAX-1:0] dr_sh_q, dr_sh_d;

  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DR_MAX-1:0] rsp_data_q, rsp_data_d;
  logic [IR_LEN-1:0] rsp_ir_q, rsp_ir_d;
  logic sel1_q, cap1_q, shift1_q, upd1_q, tdi1_q;
  logic sel1_d, cap1_d, shift1_d, upd1_d, tdi1_d;
  logic sel2_q, cap2_q, shift2_q, upd2_q, tdi2_q;
  logic sel2_d, cap2_d, shift2_d, upd2_d, tdi2_d;

  logic        accept;
  logic [31:0] dr_len;

  // Next-state and next-output logic. Outputs are derived from the state
  // being entered so every pin comes straight off a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    skip_d  = skip_q;
    len_d   = len_q;
    data_d  = data_q;
    ir_sh_d = ir_sh_q;
    dr_sh_d = dr_sh_q;
    accept  = bus.cmd_valid && ready_q;
    // Oversized lengths are clamped to the width of the data register.
    dr_len  = (32'(len_q) > DR_MAX_U) ? DR_MAX_U : 32'(len_q);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          func_d  = bus.cmd_func;
          skip_d  = bus.cmd_skip_ir;
          len_d   = bus.cmd_len;
          data_d  = bus.cmd_data;
          cnt_d   = '0;
          ir_sh_d = '0;
          dr_sh_d = '0;
          if (!bus.cmd_skip_ir)        state_d = IR_CAP;
          else if (bus.cmd_len != '0)  state_d = DR_CAP;
          else                         state_d = DONE;
        end
      end
      IR_CAP: begin
        state_d = IR_SHIFT;
        cnt_d   = '0;
      end
      IR_SHIFT: begin
        ir_sh_d = ir_sh_q | (IR_LEN'(bus.tdo1) << cnt_q);
        if (32'(cnt_q) == IR_LAST) begin
          state_d = IR_UPD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IR_UPD:  state_d = (len_q != '0) ? GAP : DONE;
      GAP:     state_d = DR_CAP;
      DR_CAP: begin
        state_d = DR_SHIFT;
        cnt_d   = '0;
      end
      DR_SHIFT: begin
        dr_sh_d = dr_sh_q | (DR_MAX'(bus.tdo2) << cnt_q);
        if (32'(cnt_q) == dr_len - 32'd1) begin
          state_d = DR_UPD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DR_UPD:  state_d = DONE;
      default: state_d = IDLE;
    endcase

    ready_d     = (state_d == IDLE) || (state_d == DONE);
    rsp_valid_d = (state_d == DONE);

    sel1_d   = (state_d == IR_CAP) || (state_d == IR_SHIFT) || (state_d == IR_UPD);
    cap1_d   = (state_d == IR_CAP);
    shift1_d = (state_d == IR_SHIFT);
    upd1_d   = (state_d == IR_UPD);
    tdi1_d   = shift1_d && (|((func_d >> cnt_d) & IR_LEN'(1)));

    sel2_d   = (state_d == DR_CAP) || (state_d == DR_SHIFT) || (state_d == DR_UPD);
    cap2_d   = (state_d == DR_CAP);
    shift2_d = (state_d == DR_SHIFT);
    upd2_d   = (state_d == DR_UPD);
    tdi2_d   = shift2_d && (|((data_d >> cnt_d) & DR_MAX'(1)));

    rsp_data_d = rsp_data_q;
    rsp_ir_d   = rsp_ir_q;
    if (state_d == DONE) begin
      if (!skip_d) rsp_ir_d = ir_sh_d;
      rsp_data_d = (len_d == '0) ? '0 : dr_sh_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      func_q      <= '0;
      skip_q      <= 1'b0;
      len_q       <= '0;
      data_q      <= '0;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      sel1_q      <= 1'b0;
      cap1_q      <= 1'b0;
      shift1_q    <= 1'b0;
      upd1_q      <= 1'b0;
      tdi1_q      <= 1'b0;
      sel2_q      <= 1'b0;
      cap2_q      <= 1'b0;
      shift2_q    <= 1'b0;
      upd2_q      <= 1'b0;
      tdi2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      func_q      <= func_d;
      skip_q      <= skip_d;
      len_q       <= len_d;
      data_q      <= data_d;
      ir_sh_q     <= ir_sh_d;
      dr_sh_q     <= dr_sh_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      sel1_q      <= sel1_d;
      cap1_q      <= cap1_d;
      shift1_q    <= shift1_d;
      upd1_q      <= upd1_d;
      tdi1_q      <= tdi1_d;
      sel2_q      <= sel2_d;
      cap2_q      <= cap2_d;
      shift2_q    <= shift2_d;
      upd2_q      <= upd2_d;
      tdi2_q      <= tdi2_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ir    = rsp_ir_q;
  assign bus.sel1      = sel1_q;
  assign bus.capture1  = cap1_q;
  assign bus.shift1    = shift1_q;
  assign bus.update1   = upd1_q;
  assign bus.tdi1      = tdi1_q;
  assign bus.sel2      = sel2_q;
  assign bus.capture2  = cap2_q;
  assign bus.shift2    = shift2_q;
  assign bus.update2   = upd2_q;
  assign bus.tdi2      = tdi2_q;

endmodule

// File: tb/tb_jtag_user_seq.sv
// Purpose: self-checking bench for jtag_user_seq using a table of directed commands
// plus hand-written back-to-back and reset-abort sequences.
// Cycle n is observed on the falling edge after the n-th rising edge following acceptance.
module tb_jtag_user_seq;
  localparam int IR_LEN = 8;
  localparam int DR_MAX = 32;
  localparam int LW     = 6;

  // mode: 0 = TDO2 from 12-bit shift register model, 1 = TDO1/TDO2 loop back TDI, 2 = TDO1 tied 1
  typedef struct {
    logic        skip;
    logic [7:0]  func;
    logic [5:0]  len;
    logic [31:0] data;
    int          mode;
    int          exp_cyc;
    logic [31:0] exp_data;
    logic [7:0]  exp_ir;
    int          exp_sh1;
    int          exp_sh2;
    int          exp_upd1;
    int          exp_upd2;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   mode;
  logic sr_load;
  logic [11:0] sr;
  vec_t vecs[8];

  jtag_user_seq_if #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .LW(LW)) bus ();

  jtag_user_seq #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .LW(LW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 12-bit user data register: shifts TDI2 in at the top, TDO2 is bit 0.
  always @(posedge clk) begin
    if (sr_load)          sr <= 12'hFFF;
    else if (bus.shift2)  sr <= {bus.tdi2, sr[11:1]};
  end

  assign bus.tdo1 = (mode == 2) ? 1'b1 : bus.tdi1;
  assign bus.tdo2 = (mode == 0) ? sr[0] : bus.tdi2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] strobes();
    return {bus.sel1, bus.capture1, bus.shift1, bus.update1, bus.tdi1,
            bus.sel2, bus.capture2, bus.shift2, bus.update2, bus.tdi2};
  endfunction

  task automatic drive_cmd(input logic skip, input logic [7:0] func, input logic [5:0] len,
                           input logic [31:0] data);
    bus.cmd_valid   = 1'b1;
    bus.cmd_skip_ir = skip;
    bus.cmd_func    = func;
    bus.cmd_len     = len;
    bus.cmd_data    = data;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int cyc, sh1, sh2, s1, s2, u1, u2, bad;
    logic [7:0]  tseq;
    logic [31:0] got_d;
    logic [7:0]  got_ir;
    cyc = -1; sh1 = 0; sh2 = 0; s1 = 0; s2 = 0; u1 = -1; u2 = -1; bad = 0;
    tseq = '0; got_d = '0; got_ir = '0;
    mode = v.mode;
    drive_cmd(v.skip, v.func, v.len, v.data);
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
      if (bus.shift1) begin
        if (sh1 < 8) tseq[sh1] = bus.tdi1;
        sh1++;
      end
      if (bus.shift2) sh2++;
      if (bus.sel1) s1++;
      if (bus.sel2) s2++;
      if (bus.update1) u1 = n;
      if (bus.update2) u2 = n;
      if (bus.sel1 && bus.sel2) bad++;
      if (bus.tdi1 && !bus.shift1) bad++;
      if (bus.tdi2 && !bus.shift2) bad++;
      if ((bus.capture1 || bus.shift1 || bus.update1) && !bus.sel1) bad++;
      if ((bus.capture2 || bus.shift2 || bus.update2) && !bus.sel2) bad++;
      if (bus.rsp_valid) begin
        cyc    = n;
        got_d  = bus.rsp_data;
        got_ir = bus.rsp_ir;
        break;
      end
    end
    chk($sformatf("%s.done_cycle", tag), cyc, v.exp_cyc);
    chk($sformatf("%s.rsp_data", tag), got_d, v.exp_data);
    chk($sformatf("%s.rsp_ir", tag), got_ir, v.exp_ir);
    chk($sformatf("%s.shift1_cycles", tag), sh1, v.exp_sh1);
    chk($sformatf("%s.shift2_cycles", tag), sh2, v.exp_sh2);
    chk($sformatf("%s.sel1_cycles", tag), s1, (v.exp_sh1 != 0) ? v.exp_sh1 + 2 : 0);
    chk($sformatf("%s.sel2_cycles", tag), s2, (v.exp_sh2 != 0) ? v.exp_sh2 + 2 : 0);
    chk($sformatf("%s.update1_cycle", tag), u1, v.exp_upd1);
    chk($sformatf("%s.update2_cycle", tag), u2, v.exp_upd2);
    chk($sformatf("%s.signal_rules", tag), bad, 0);
    if (v.exp_sh1 != 0) chk($sformatf("%s.tdi1_seq", tag), tseq, v.func);
    @(negedge clk);
    chk($sformatf("%s.valid_pulse_end", tag), bus.rsp_valid, 1'b0);
    chk($sformatf("%s.ready_after", tag), bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   rdy_hi, cyc_b, vhi;
    logic [31:0] b_data;
    logic [7:0]  b_ir;
    vec_t post;

    //          skip  func   len    data           mode cyc data          ir     sh1 sh2 upd1 upd2
    vecs[0] = '{1'b0, 8'h0C, 6'd12, 32'h0000_0A5A, 0,   26, 32'h0000_0FFF, 8'h0C, 8,  12, 10,  25};
    vecs[1] = '{1'b0, 8'h0C, 6'd12, 32'h0000_0A5A, 0,   26, 32'h0000_0A5A, 8'h0C, 8,  12, 10,  25};
    vecs[2] = '{1'b1, 8'h77, 6'd32, 32'hDEAD_BEEF, 1,   35, 32'hDEAD_BEEF, 8'h0C, 0,  32, -1,  34};
    vecs[3] = '{1'b0, 8'h3F, 6'd0,  32'h1234_5678, 2,   11, 32'h0000_0000, 8'hFF, 8,  0,  10,  -1};
    vecs[4] = '{1'b1, 8'h00, 6'd40, 32'h1234_5678, 1,   35, 32'h1234_5678, 8'hFF, 0,  32, -1,  34};
    vecs[5] = '{1'b1, 8'h5A, 6'd0,  32'hFFFF_FFFF, 1,   1,  32'h0000_0000, 8'hFF, 0,  0,  -1,  -1};
    vecs[6] = '{1'b0, 8'hA5, 6'd5,  32'h0000_0013, 1,   19, 32'h0000_0013, 8'hA5, 8,  5,  10,  18};
    vecs[7] = '{1'b1, 8'h00, 6'd3,  32'hFFFF_FFFF, 1,   6,  32'h0000_0007, 8'hA5, 0,  3,  -1,  5};

    mode    = 1;
    sr_load = 1'b1;
    rst_n   = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_skip_ir = 1'b0;
    bus.cmd_func    = '0;
    bus.cmd_len     = '0;
    bus.cmd_data    = '0;

    @(negedge clk);
    chk("reset.cmd_ready", bus.cmd_ready, 1'b1);
    chk("reset.rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset.rsp_data", bus.rsp_data, 32'h0);
    chk("reset.rsp_ir", bus.rsp_ir, 8'h0);
    chk("reset.strobes", strobes(), 10'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    sr_load = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: A = full 0x11/len 4/0x5, B = full 0x22/len 4/0xA held valid from cycle 0.
    mode = 1;
    rdy_hi = 0; cyc_b = -1; b_data = '0; b_ir = '0;
    drive_cmd(1'b0, 8'h11, 6'd4, 32'h5);
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) drive_cmd(1'b0, 8'h22, 6'd4, 32'hA);
      if (n < 18 && bus.cmd_ready) rdy_hi++;
      if (n == 18) begin
        chk("b2b.a_rsp_valid", bus.rsp_valid, 1'b1);
        chk("b2b.a_ready_in_done", bus.cmd_ready, 1'b1);
        chk("b2b.a_rsp_data", bus.rsp_data, 32'h5);
        chk("b2b.a_rsp_ir", bus.rsp_ir, 8'h11);
      end
      if (n == 19) begin
        bus.cmd_valid = 1'b0;
        chk("b2b.b_ir_cap", {bus.sel1, bus.capture1}, 2'b11);
        chk("b2b.b_ready_low", bus.cmd_ready, 1'b0);
      end
      if (n > 18 && bus.rsp_valid && cyc_b < 0) begin
        cyc_b  = n;
        b_data = bus.rsp_data;
        b_ir   = bus.rsp_ir;
      end
    end
    chk("b2b.ready_between", rdy_hi, 0);
    chk("b2b.b_done_cycle", cyc_b, 36);
    chk("b2b.b_rsp_data", b_data, 32'hA);
    chk("b2b.b_rsp_ir", b_ir, 8'h22);

    // Reset abort in DR_SHIFT cycle 5 (absolute cycle 18) of a full len-16 command.
    mode = 1;
    drive_cmd(1'b0, 8'h5A, 6'd16, 32'h0000_BEEF);
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) bus.cmd_valid = 1'b0;
    end
    chk("abort.in_dr_shift", {bus.sel2, bus.shift2}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("abort.strobes", strobes(), 10'h0);
    chk("abort.cmd_ready", bus.cmd_ready, 1'b1);
    chk("abort.rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort.rsp_data", bus.rsp_data, 32'h0);
    chk("abort.rsp_ir", bus.rsp_ir, 8'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vhi = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid || !bus.cmd_ready) vhi++;
    end
    chk("abort.no_response", vhi, 0);

    //        skip  func   len   data           mode cyc data           ir     sh1 sh2 upd1 upd2
    post = '{1'b1, 8'h00, 6'd8, 32'h0000_003C, 1,   11, 32'h0000_003C, 8'h00, 0,  8,  -1,  10};
    run_cmd(post, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
